// File: rtl/overlap_out_packer_if.sv
// Stream bundle for overlap_out_packer.
// Carries the unthrottled input vector from the overlap stage, the flush
// control, and the ready/valid output beat with its row/frame tags and status.
//   master : producer/consumer side (drives clear, vector in, ready)
//   slave  : packer side (drives head vector, valid, tags, status)
interface overlap_out_packer_if #(
    parameter int PIX_WIDTH     = 8,
    parameter int SIZE_OF_INPUT = 5,
    parameter int FIFO_DEPTH    = 4
);
    localparam int W  = PIX_WIDTH * SIZE_OF_INPUT;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          clear_i;
    logic          valid_i;
    logic [W-1:0]  buffer_i;
    logic [W-1:0]  m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_row_o;
    logic          m_last_frame_o;
    logic          frame_done_o;
    logic          overflow_o;
    logic [LW-1:0] level_o;

    modport master (
        output clear_i, valid_i, buffer_i, m_ready_i,
        input  m_data_o, m_valid_o, m_last_row_o, m_last_frame_o,
               frame_done_o, overflow_o, level_o
    );

    modport slave (
        input  clear_i, valid_i, buffer_i, m_ready_i,
        output m_data_o, m_valid_o, m_last_row_o, m_last_frame_o,
               frame_done_o, overflow_o, level_o
    );
endinterface

// File: rtl/overlap_out_packer.sv
// overlap_out_packer
// Captures result vectors from the overlap-add stage (no backpressure there)
// into a small first-word-fall-through FIFO and replays them on a ready/valid
// stream tagged with row and frame boundaries. Vectors arriving into a full
// FIFO with no simultaneous read are dropped and flagged by sticky overflow.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active high (priority over clear_i)
//   bus    : overlap_out_packer_if.slave
//            clear_i flush, valid_i/buffer_i input vector,
//            m_data_o/m_valid_o/m_ready_i output stream,
//            m_last_row_o/m_last_frame_o beat tags, frame_done_o pulse,
//            overflow_o sticky drop flag, level_o occupancy
module overlap_out_packer #(
    parameter int PIX_WIDTH      = 8,
    parameter int SIZE_OF_INPUT  = 5,
    parameter int VEC_PER_ROW    = 2,
    parameter int ROWS_PER_FRAME = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    overlap_out_packer_if.slave bus
);
    localparam int W  = PIX_WIDTH * SIZE_OF_INPUT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (VEC_PER_ROW > 1) ? $clog2(VEC_PER_ROW) : 1;
    localparam int RW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    state_t        state;
    logic          frame_done, overflow;

    logic full, not_empty, rd, wr, last_row, last_frame;

    assign full       = (level == LW'(FIFO_DEPTH));
    assign not_empty  = (level != '0);
    assign rd         = not_empty && bus.m_ready_i;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr         = bus.valid_i && (!full || rd);
    assign last_row   = not_empty && (col_cnt == CW'(VEC_PER_ROW - 1));
    assign last_frame = last_row && (row_cnt == RW'(ROWS_PER_FRAME - 1));

    assign bus.m_data_o       = mem[rd_ptr];
    assign bus.m_valid_o      = not_empty;
    assign bus.m_last_row_o   = last_row;
    assign bus.m_last_frame_o = last_frame;
    assign bus.frame_done_o   = frame_done;
    assign bus.overflow_o     = overflow;
    assign bus.level_o        = level;

    // Storage needs no reset: contents are only observed while level != 0.
    always_ff @(posedge clk_i) begin
        if (wr) mem[wr_ptr] <= bus.buffer_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            state      <= IDLE;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Pointers wrap naturally: depth is a power of two.
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            if (bus.valid_i && !wr) overflow <= 1'b1;

            case ({wr, rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (rd) begin
                if (last_frame) begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                end else if (last_row) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end

            case (state)
                IDLE: if (rd) begin
                    // A one-beat frame completes without leaving IDLE.
                    if (last_frame) frame_done <= 1'b1;
                    else            state      <= ACTIVE;
                end
                ACTIVE: if (rd && last_frame) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
